mem_stage: RTL and testbench

Memory-access stage of the RISC-V pipeline. It sits downstream of the execute stage and consumes its ALU result as a load/store address or as a pass-through result. It drives a request/grant/response data-memory port and performs byte-lane alignment plus load sign/zero extension. It emits one write-back beat per accepted instruction and stalls execute while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: request/grant/response data-memory port, byte-lane
// alignment, load extension and a registered one-beat write-back per instruction.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rdata2,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_RegWrite,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we, r_regwrite;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [15:0] r_cnt;

  logic        w_accept, w_memop, w_f3_ok, w_misalign, w_fault_acc, w_start;
  logic        w_done, w_timeout, w_busy;
  logic [31:0] w_st_wdata, w_ld_data;
  logic [3:0]  w_st_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Accept-time decode: legality, alignment and store lane placement
  always_comb begin
    w_accept   = ex_valid && (r_state == IDLE);
    w_memop    = MemRead | MemWrite;
    w_f3_ok    = 1'b0;
    if (MemRead) w_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else         w_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    w_misalign = ((funct3[1:0] == 2'b01) && ALU_result[0]) ||
                 ((funct3[1:0] == 2'b10) && (ALU_result[1:0] != 2'b00));
    w_fault_acc = w_memop && ((MemRead && MemWrite) || !w_f3_ok || w_misalign);
    w_start     = w_accept && w_memop && !w_fault_acc;

    w_st_be    = 4'b1111;
    w_st_wdata = rdata2;
    case (funct3[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << ALU_result[1:0];
        w_st_wdata = {4{rdata2[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << {ALU_result[1], 1'b0};
        w_st_wdata = {2{rdata2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction and completion/timeout detection
  always_comb begin
    w_byte    = 8'(dmem_rdata >> {r_addr[1:0], 3'b000});
    w_half    = 16'(dmem_rdata >> {r_addr[1], 4'b0000});
    w_ld_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h0, w_byte};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_data = dmem_rdata;
    endcase
    w_busy    = (r_state == REQ) || (r_state == WAIT_R);
    w_done    = ((r_state == REQ) && dmem_gnt && r_we) ||
                ((r_state == WAIT_R) && dmem_rvalid);
    // A load granted on the final cycle still times out: it cannot finish in time
    w_timeout = w_busy && (r_cnt == TO_LAST) && !w_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = REQ;
      REQ: begin
        if (w_timeout)     w_next = IDLE;
        else if (dmem_gnt) w_next = r_we ? IDLE : WAIT_R;
      end
      WAIT_R:  if (w_timeout || dmem_rvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ex_ready   = (r_state == IDLE);
    dmem_req   = (r_state == REQ);
    dmem_we    = dmem_req && r_we;
    dmem_addr  = dmem_req ? {r_addr[31:2], 2'b00} : '0;
    dmem_wdata = dmem_req ? r_wdata : '0;
    dmem_be    = dmem_req ? r_be : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_regwrite <= 1'b0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_start) begin
        r_addr     <= ALU_result;
        r_wdata    <= w_st_wdata;
        r_be       <= w_st_be;
        r_we       <= MemWrite;
        r_regwrite <= RegWrite;
        r_funct3   <= funct3;
        r_rd       <= rd;
        r_cnt      <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_RegWrite <= 1'b0;
      mem_fault   <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_RegWrite <= 1'b0;
      mem_fault   <= 1'b0;
      if (w_accept && !w_memop) begin
        wb_valid    <= 1'b1;
        wb_rd       <= rd;
        wb_data     <= ALU_result;
        wb_RegWrite <= RegWrite;
      end else if (w_accept && w_fault_acc) begin
        wb_valid  <= 1'b1;
        wb_rd     <= rd;
        mem_fault <= 1'b1;
      end else if (w_timeout) begin
        wb_valid  <= 1'b1;
        wb_rd     <= r_rd;
        mem_fault <= 1'b1;
      end else if ((r_state == REQ) && dmem_gnt && r_we) begin
        wb_valid <= 1'b1;
        wb_rd    <= r_rd;
      end else if ((r_state == WAIT_R) && dmem_rvalid) begin
        wb_valid    <= 1'b1;
        wb_rd       <= r_rd;
        wb_data     <= w_ld_data;
        wb_RegWrite <= r_regwrite;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, faults,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ALU_result, rdata2;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        MemRead, MemWrite, RegWrite;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_RegWrite, mem_fault;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALU_result(ALU_result), .rdata2(rdata2), .funct3(funct3), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_RegWrite(wb_RegWrite), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ALU_result = '0; rdata2 = '0; funct3 = '0; rd = '0;
    MemRead = 0; MemWrite = 0; RegWrite = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       input logic [4:0] r, input logic mr, input logic mw, input logic rw);
    ex_valid = 1; ALU_result = a; rdata2 = d; funct3 = f3; rd = r;
    MemRead = mr; MemWrite = mw; RegWrite = rw;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_rd, wb_data,
         wb_RegWrite, mem_fault} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%b wbv=%b rd=%0d data=%h rw=%b flt=%b required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_rd, wb_data, wb_RegWrite, mem_fault);
    end
    n_tests++;
    if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ex_ready); end
    tick(); tick();
    rst_n = 1;
    tick();
    // gnt/rvalid in IDLE must be ignored
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    n_tests++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got wbv=%b req=%b required 0 0", wb_valid, dmem_req);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_txn();
    issue(32'h0000_0040, '0, 3'b010, 5'd3, 1, 0, 1);
    tick();
    ex_valid = 0;
    n_tests++;
    if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_before: got %b required 1", dmem_req); end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_async: got req=%b ready=%b required 0 1", dmem_req, ex_ready);
    end
    tick();
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_rvalid = 0;
    n_tests++;
    if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_no_wb: got wbv=%b ready=%b required 0 1", wb_valid, ex_ready);
    end
    idle_inputs();
  endtask

  task automatic test_alu();
    issue(32'h0000_1234, '0, 3'b000, 5'd5, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_rd !== 5'd5 || wb_RegWrite !== 1'b1 ||
          ex_ready !== 1'b1 || mem_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL alu_beat%0d: got v=%b data=%h rd=%0d rw=%b rdy=%b flt=%b required 1 00001234 5 1 1 0",
                 i, wb_valid, wb_data, wb_rd, wb_RegWrite, ex_ready, mem_fault);
      end
    end
    idle_inputs();
    tick();
    n_tests++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
      n_fail++; $display("FAIL alu_end: got v=%b data=%h required 0 0", wb_valid, wb_data);
    end
  endtask

  task automatic test_store_sb();
    issue(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 5'd9, 0, 1, 1);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h1000 || dmem_be !== 4'b1000 ||
          dmem_wdata !== 32'hDDDD_DDDD || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_req%0d: got req=%b we=%b addr=%h be=%b wdata=%h rdy=%b wbv=%b required 1 1 00001000 1000 dddddddd 0 0",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready, wb_valid);
      end
      tick();
    end
    dmem_gnt = 1;
    n_tests++;
    if (dmem_req !== 1'b1 || ex_ready !== 1'b0) begin
      n_fail++; $display("FAIL sb_gnt_cycle: got req=%b rdy=%b required 1 0", dmem_req, ex_ready);
    end
    tick();
    dmem_gnt = 0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_data !== 32'h0 || dmem_req !== 1'b0 ||
        ex_ready !== 1'b1 || mem_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_wb: got v=%b rw=%b data=%h req=%b rdy=%b flt=%b required 1 0 0 0 1 0",
               wb_valid, wb_RegWrite, wb_data, dmem_req, ex_ready, mem_fault);
    end
    tick();
  endtask

  task automatic test_store_sh_sw(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                                  input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(a, d, f3, 5'd1, 0, 1, 0);
    tick();
    idle_inputs();
    dmem_gnt = 1;
    n_tests++;
    if (dmem_req !== 1'b1 || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be || dmem_wdata !== exp_wd) begin
      n_fail++;
      $display("FAIL store_lanes f3=%b: got req=%b addr=%h be=%b wdata=%h required 1 %h %b %h",
               f3, dmem_req, dmem_addr, dmem_be, dmem_wdata, {a[31:2], 2'b00}, exp_be, exp_wd);
    end
    tick();
    dmem_gnt = 0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL store_wb f3=%b: got v=%b rw=%b required 1 0", f3, wb_valid, wb_RegWrite);
    end
  endtask

  task automatic test_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] word,
                           input logic [31:0] exp);
    issue(a, '0, f3, 5'd7, 1, 0, 1);
    tick();
    idle_inputs();
    dmem_gnt = 1;
    n_tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {a[31:2], 2'b00}) begin
      n_fail++;
      $display("FAIL load_req f3=%b: got req=%b we=%b addr=%h required 1 0 %h", f3, dmem_req, dmem_we, dmem_addr, {a[31:2], 2'b00});
    end
    tick();
    dmem_gnt = 0;
    dmem_rvalid = 1; dmem_rdata = word;
    n_tests++;
    if (dmem_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_wait f3=%b: got req=%b rdy=%b wbv=%b required 0 0 0", f3, dmem_req, ex_ready, wb_valid);
    end
    tick();
    dmem_rvalid = 0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== 5'd7 || wb_RegWrite !== 1'b1 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_wb a=%h f3=%b: got v=%b data=%h rd=%0d rw=%b rdy=%b required 1 %h 7 1 1",
               a, f3, wb_valid, wb_data, wb_rd, wb_RegWrite, ex_ready, exp);
    end
    tick();
  endtask

  task automatic test_fault(input logic [31:0] a, input logic [2:0] f3, input logic mr, input logic mw);
    issue(a, 32'h5555_5555, f3, 5'd4, mr, mw, 1);
    tick();
    idle_inputs();
    n_tests++;
    if (mem_fault !== 1'b1 || wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_data !== 32'h0 ||
        dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fault a=%h f3=%b mr=%b mw=%b: got flt=%b v=%b rw=%b data=%h req=%b rdy=%b required 1 1 0 0 0 1",
               a, f3, mr, mw, mem_fault, wb_valid, wb_RegWrite, wb_data, dmem_req, ex_ready);
    end
    tick();
    n_tests++;
    if (mem_fault !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL fault_pulse: got flt=%b v=%b req=%b required 0 0 0", mem_fault, wb_valid, dmem_req);
    end
  endtask

  task automatic test_timeout();
    issue(32'h0000_0040, '0, 3'b010, 5'd8, 1, 0, 1);
    tick();                       // cycle T+1: REQ, counter 0
    idle_inputs();
    dmem_gnt = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();                     // cycles T+2..T+4
      dmem_gnt = 0;
      n_tests++;
      if (mem_fault !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early%0d: got flt=%b v=%b rdy=%b required 0 0 0", c, mem_fault, wb_valid, ex_ready);
      end
    end
    tick();                       // cycle T+5
    n_tests++;
    if (mem_fault !== 1'b1 || wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fault: got flt=%b v=%b rw=%b rdy=%b req=%b required 1 1 0 1 0",
               mem_fault, wb_valid, wb_RegWrite, ex_ready, dmem_req);
    end
    issue(32'h0000_00AB, '0, 3'b000, 5'd2, 0, 0, 1);
    tick();
    idle_inputs();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hAB || wb_rd !== 5'd2 || mem_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_next_op: got v=%b data=%h rd=%0d flt=%b required 1 000000ab 2 0", wb_valid, wb_data, wb_rd, mem_fault);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_txn();
    test_alu();
    test_store_sb();
    test_store_sh_sw(32'h0000_1002, 3'b001, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store_sh_sw(32'h0000_1004, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    test_load(32'h0000_2002, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001);
    test_load(32'h0000_2002, 3'b101, 32'h8001_7FFF, 32'h0000_8001);
    test_load(32'h0000_2001, 3'b000, 32'h8001_7FFF, 32'h0000_007F);
    test_load(32'h0000_2003, 3'b000, 32'h8001_7FFF, 32'hFFFF_FF80);
    test_load(32'h0000_2003, 3'b100, 32'h8001_7FFF, 32'h0000_0080);
    test_load(32'h0000_2000, 3'b010, 32'h8001_7FFF, 32'h8001_7FFF);
    test_fault(32'h0000_3001, 3'b010, 1, 0);
    test_fault(32'h0000_3000, 3'b010, 1, 1);
    test_fault(32'h0000_3000, 3'b011, 0, 1);
    test_fault(32'h0000_3000, 3'b110, 1, 0);
    test_fault(32'h0000_3001, 3'b001, 0, 1);
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
